// File: rtl/clint_timer.sv
// Machine timer and software-interrupt responder on the drisc data bus.
// Holds the 64-bit mtime/mtimecmp pair and the msip flag, and drives the level interrupts.
module clint_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000,
  parameter int unsigned PRESCALER    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic [31:0] data_bus_in,
  input  logic [1:0]  data_size,
  input  logic        write,
  input  logic        read,
  output logic [31:0] data_bus_out,
  output logic        select,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALER - 1);

  logic [15:0] r_pre;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_mtime_hi_shadow;
  logic        r_msip;
  logic        r_timer_irq;
  logic        r_sw_irq;

  logic        w_select;
  logic        w_wr;
  logic        w_tick;
  logic [2:0]  w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_select = (address_bus & ~32'h1F) == BASE_ADDRESS;
  assign w_idx    = address_bus[4:2];
  assign w_wr     = w_select & write;
  assign w_tick   = (r_pre == PRE_LAST);

  // Lane enables; misaligned or reserved-size stores leave w_be at zero.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = data_bus_in;
    case (data_size)
      2'd0: begin
        w_be    = 4'b0001 << address_bus[1:0];
        w_wdata = {4{data_bus_in[7:0]}};
      end
      2'd1: begin
        if (!address_bus[0]) w_be = address_bus[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_bus_in[15:0]}};
      end
      2'd2: begin
        if (address_bus[1:0] == 2'b00) w_be = 4'b1111;
      end
      default: w_be = 4'b0000;
    endcase
    if (!w_wr) w_be = 4'b0000;
  end

  assign w_wr_mtime_lo = (w_idx == 3'd2) && (w_be != 4'b0000);
  assign w_wr_mtime_hi = (w_idx == 3'd3) && (w_be != 4'b0000);

  always_comb begin
    w_rdata = 32'h0;
    if (w_select && read) begin
      case (w_idx)
        3'd0:    w_rdata = {31'h0, r_msip};
        3'd2:    w_rdata = r_mtime[31:0];
        3'd3:    w_rdata = r_mtime_hi_shadow;
        3'd4:    w_rdata = r_mtimecmp[31:0];
        3'd5:    w_rdata = r_mtimecmp[63:32];
        default: w_rdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre <= 16'h0;
    end else begin
      r_pre <= w_tick ? 16'h0 : r_pre + 16'd1;
    end
  end

  // A store to either mtime half wins over the tick; the untouched half holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mtime <= 64'h0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= merge_lanes(r_mtime[31:0], w_wdata, w_be);
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= merge_lanes(r_mtime[63:32], w_wdata, w_be);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip     <= 1'b0;
    end else begin
      if (w_idx == 3'd4) r_mtimecmp[31:0]  <= merge_lanes(r_mtimecmp[31:0], w_wdata, w_be);
      if (w_idx == 3'd5) r_mtimecmp[63:32] <= merge_lanes(r_mtimecmp[63:32], w_wdata, w_be);
      if (w_idx == 3'd0 && w_be[0]) r_msip <= w_wdata[0];
    end
  end

  // Reading the low word latches the high word so low-then-high is coherent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mtime_hi_shadow <= 32'h0;
      r_timer_irq       <= 1'b0;
      r_sw_irq          <= 1'b0;
    end else begin
      if (w_select && read && w_idx == 3'd2) r_mtime_hi_shadow <= r_mtime[63:32];
      r_timer_irq <= (r_mtime >= r_mtimecmp);
      r_sw_irq    <= r_msip;
    end
  end

  assign data_bus_out       = w_rdata;
  assign select             = w_select;
  assign timer_interrupt    = r_timer_irq;
  assign software_interrupt = r_sw_irq;

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: stimulus queues expected values, a negedge monitor compares.
// Two instances share the bus: PRESCALER = 1 and PRESCALER = 4.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int K_D1 = 0, K_S1 = 1, K_T1 = 2, K_W1 = 3, K_D4 = 4, K_T4 = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_bus = BASE;
  logic [31:0] data_bus_in = 32'h0;
  logic [1:0]  data_size = 2'd2;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        sample = 1'b0;

  logic [31:0] dout1, dout4;
  logic        sel1, sel4, tirq1, tirq4, sirq1, sirq4;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  clint_timer #(.BASE_ADDRESS(BASE), .PRESCALER(1)) u_dut1 (
    .clock(clock), .reset(reset), .address_bus(address_bus), .data_bus_in(data_bus_in),
    .data_size(data_size), .write(write), .read(read), .data_bus_out(dout1),
    .select(sel1), .timer_interrupt(tirq1), .software_interrupt(sirq1));

  clint_timer #(.BASE_ADDRESS(BASE), .PRESCALER(4)) u_dut4 (
    .clock(clock), .reset(reset), .address_bus(address_bus), .data_bus_in(data_bus_in),
    .data_size(data_size), .write(write), .read(read), .data_bus_out(dout4),
    .select(sel4), .timer_interrupt(tirq4), .software_interrupt(sirq4));

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clock) begin
    if (sample) begin
      while (sb.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.kind)
          K_D1:    act = dout1;
          K_S1:    act = {31'h0, sel1};
          K_T1:    act = {31'h0, tirq1};
          K_W1:    act = {31'h0, sirq1};
          K_D4:    act = dout4;
          K_T4:    act = {31'h0, tirq4};
          default: act = 32'hDEAD_BEEF;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    sample      = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    data_size   = 2'd2;
    data_bus_in = 32'h0;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
    sample = 1'b1;
  endtask

  task automatic do_wr(input logic [7:0] off, input logic [1:0] sz, input logic [31:0] d);
    address_bus = BASE + 32'(off);
    write       = 1'b1;
    data_size   = sz;
    data_bus_in = d;
    step();
  endtask

  task automatic do_rd(input logic [7:0] off, input logic [31:0] v, input string nm);
    address_bus = BASE + 32'(off);
    read        = 1'b1;
    expect_v(K_D1, v, nm);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Timer compare with PRESCALER = 4: mtime reaches 20 at the 80th edge after release.
    do_reset();
    do_wr(8'h10, 2'd2, 32'd20);
    do_wr(8'h14, 2'd2, 32'd0);
    repeat (78) step();
    address_bus = BASE + 32'h08;
    read = 1'b1;
    expect_v(K_D4, 32'd20, "p4_mtime_at_e80");
    expect_v(K_T4, 32'd0, "p4_tirq_before_rise");
    step();
    expect_v(K_T4, 32'd1, "p4_tirq_rise");
    address_bus = BASE + 32'h14;
    write = 1'b1;
    data_bus_in = 32'd1;
    step();
    expect_v(K_T4, 32'd1, "p4_tirq_on_cmp_write_edge");
    step();
    expect_v(K_T4, 32'd0, "p4_tirq_fall");
    step();

    // Reset values with PRESCALER = 1.
    do_reset();
    do_rd(8'h08, 32'h0, "mtime_first_cycle");
    do_rd(8'h10, 32'hFFFF_FFFF, "mtimecmp_lo_reset");
    expect_v(K_T1, 32'd0, "tirq_reset");
    do_rd(8'h14, 32'hFFFF_FFFF, "mtimecmp_hi_reset");
    do_rd(8'h00, 32'h0, "msip_reset");
    address_bus = BASE + 32'h10;
    expect_v(K_D1, 32'h0, "dout_read_low");
    step();

    // msip and software interrupt.
    do_wr(8'h00, 2'd2, 32'h1);
    expect_v(K_W1, 32'd0, "sirq_on_write_edge");
    step();
    expect_v(K_W1, 32'd1, "sirq_rise");
    step();
    do_wr(8'h01, 2'd0, 32'h0);
    expect_v(K_W1, 32'd1, "sirq_after_byte1");
    do_rd(8'h00, 32'h1, "msip_after_byte1");
    do_wr(8'h00, 2'd0, 32'h0);
    step();
    expect_v(K_W1, 32'd0, "sirq_fall");
    step();

    // Reserved words.
    do_wr(8'h04, 2'd2, 32'hFFFF_FFFF);
    do_rd(8'h04, 32'h0, "reserved_04");
    do_wr(8'h18, 2'd2, 32'hFFFF_FFFF);
    do_rd(8'h18, 32'h0, "reserved_18");

    // Sub-word and illegal stores to mtimecmp.
    do_wr(8'h12, 2'd1, 32'h0000_ABCD);
    do_rd(8'h10, 32'hABCD_FFFF, "half_store_hi_lanes");
    do_wr(8'h11, 2'd1, 32'h0000_1234);
    do_rd(8'h10, 32'hABCD_FFFF, "half_store_misaligned");
    do_wr(8'h10, 2'd3, 32'h0);
    do_rd(8'h10, 32'hABCD_FFFF, "size3_ignored");
    do_wr(8'h12, 2'd2, 32'h0);
    do_rd(8'h10, 32'hABCD_FFFF, "word_misaligned");
    do_wr(8'h13, 2'd0, 32'h0000_0012);
    do_rd(8'h10, 32'h12CD_FFFF, "byte_store_lane3");
    do_wr(8'h13, 2'd0, 32'h0000_00AB);

    // Simultaneous read and write returns the pre-edge value.
    address_bus = BASE + 32'h14;
    read = 1'b1;
    write = 1'b1;
    data_bus_in = 32'h1111_2222;
    expect_v(K_D1, 32'hFFFF_FFFF, "rw_same_cycle_old");
    step();
    do_rd(8'h14, 32'h1111_2222, "rw_same_cycle_new");

    // A store in a tick cycle discards the increment.
    do_wr(8'h08, 2'd2, 32'h1234_5678);
    do_rd(8'h08, 32'h1234_5678, "mtime_write_no_inc");

    // High read without a preceding low read returns the stale shadow.
    do_wr(8'h0C, 2'd2, 32'd5);
    do_rd(8'h0C, 32'h0, "shadow_stale");
    do_rd(8'h08, 32'h1234_567A, "mtime_lo_live");
    do_rd(8'h0C, 32'd5, "shadow_after_lo");

    // Carry into the high word, read back coherently.
    do_wr(8'h08, 2'd2, 32'hFFFF_FFFF);
    do_wr(8'h0C, 2'd2, 32'h0);
    step();
    do_rd(8'h08, 32'h0, "carry_lo");
    do_rd(8'h0C, 32'h1, "carry_hi");

    // Wrap of the 64-bit counter.
    do_wr(8'h08, 2'd2, 32'hFFFF_FFFF);
    do_wr(8'h0C, 2'd2, 32'hFFFF_FFFF);
    expect_v(K_T1, 32'd0, "wrap_tirq_before");
    step();
    expect_v(K_T1, 32'd1, "wrap_tirq_at_max");
    do_rd(8'h08, 32'h0, "wrap_mtime_lo");
    expect_v(K_T1, 32'd0, "wrap_tirq_after");
    step();

    // Window decode.
    address_bus = BASE + 32'h1C;
    read = 1'b1;
    expect_v(K_S1, 32'd1, "select_last_word");
    expect_v(K_D1, 32'h0, "reserved_1c");
    step();
    address_bus = BASE + 32'h20;
    read = 1'b1;
    expect_v(K_S1, 32'd0, "select_outside");
    expect_v(K_D1, 32'h0, "dout_outside");
    step();
    do_wr(8'h20, 2'd2, 32'h1);
    expect_v(K_W1, 32'd0, "outside_write_ignored");
    step();

    // Reset during a transaction: async clear, aborted store.
    do_wr(8'h00, 2'd2, 32'h1);
    step();
    expect_v(K_W1, 32'd1, "sirq_before_reset");
    step();
    address_bus = BASE + 32'h10;
    write = 1'b1;
    data_bus_in = 32'h0;
    reset = 1'b1;
    expect_v(K_W1, 32'd0, "sirq_async_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    write = 1'b0;
    sample = 1'b0;
    do_rd(8'h10, 32'hFFFF_FFFF, "aborted_write");
    do_rd(8'h00, 32'h0, "msip_after_reset");

    repeat (2) step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
